// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states and
// the lane-count helper used to size byte-lane logic from the data width.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RMW  = 2'd2
  } state_e;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU-side request/response bundle of the data-memory controller.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// rsp_valid is a single-cycle pulse with no back-pressure, rsp_err/rsp_rdata valid with it.
interface dmem_ctrl_if
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  size_e         req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ctrl_lane_fmt.sv
// Byte-lane formatter: extracts and extends load data from a RAM word, and
// merges sub-word store data into a RAM word (little-endian lanes).
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int LB = $clog2(DW / 8)
) (
  input  logic [DW-1:0] word_i,
  input  logic [LB-1:0] lane_i,
  input  size_e         size_i,
  input  logic          signed_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] load_o,
  output logic [DW-1:0] merge_o
);

  localparam int NB = lane_count(DW);

  int            nbytes;
  logic [DW-1:0] shifted;
  logic          sign_bit;

  always_comb begin
    nbytes = 1 << int'(size_i);
    if (nbytes > NB) nbytes = NB;
    shifted  = word_i >> {lane_i, 3'b000};
    sign_bit = signed_i & shifted[8*nbytes-1];

    load_o = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < nbytes) load_o[8*i +: 8] = shifted[8*i +: 8];
      else            load_o[8*i +: 8] = {8{sign_bit}};
    end

    // Lanes outside [lane, lane+nbytes) keep the value read from RAM.
    merge_o = word_i;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(lane_i) && i < int'(lane_i) + nbytes)
        merge_o[8*i +: 8] = wdata_i[8*(i - int'(lane_i)) +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the CPU memory stage and a single-port
// synchronous RAM: sized/extended loads, read-modify-write sub-word stores, range/alignment errors.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int            DW        = 32,
  parameter int            DEPTH     = 1024,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  dmem_ctrl_if.slave               bus,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic                     ram_wren,
  output logic [DW-1:0]            ram_data,
  input  logic [DW-1:0]            ram_q,
  output state_e                   dbg_state_o
);

  localparam int            NB   = lane_count(DW);
  localparam int            LB   = $clog2(NB);
  localparam int            IW   = $clog2(DEPTH);
  localparam logic [AW:0]   SPAN = (AW+1)'(DEPTH * NB);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [LB-1:0] lane_q;
  size_e         size_q;
  logic          signed_q;
  logic [DW-1:0] wdata_q;
  logic          rsp_q;
  logic          err_q;

  logic          accept;
  logic          req_err;
  logic          req_full;
  logic [AW:0]   req_off;
  logic [AW-1:0] align_mask;
  logic [IW-1:0] req_idx;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merge_data;

  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // An address below BASE_ADDR borrows into bit AW, so the single >= SPAN
  // test also rejects it; the top byte is valid and one past never wraps.
  assign req_off    = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign align_mask = (AW'(1) << bus.req_size) - AW'(1);
  assign req_err    = (int'(bus.req_size) > LB) ||
                      ((bus.req_addr & align_mask) != '0) ||
                      (req_off >= SPAN);
  assign req_full   = (int'(bus.req_size) == LB);
  assign req_idx    = req_off[LB +: IW];

  mem_lane_fmt #(.DW(DW), .LB(LB)) u_fmt (
    .word_i   (ram_q),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rsp_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rsp_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (req_err) begin
              rsp_q <= 1'b1;
              err_q <= 1'b1;
            end else if (bus.req_we && req_full) begin
              rsp_q <= 1'b1;
            end else begin
              idx_q    <= req_idx;
              lane_q   <= bus.req_addr[LB-1:0];
              size_q   <= bus.req_size;
              signed_q <= bus.req_signed;
              wdata_q  <= bus.req_wdata;
              state_q  <= bus.req_we ? S_RMW : S_LOAD;
            end
          end
        end
        S_LOAD: state_q <= S_IDLE;
        S_RMW: begin
          rsp_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Load data and the RMW write go out combinationally from the registered
  // state so each completes one cycle after the RAM read was issued.
  always_comb begin
    ram_addr      = '0;
    ram_wren      = 1'b0;
    ram_data      = '0;
    bus.rsp_valid = rsp_q;
    bus.rsp_err   = err_q;
    bus.rsp_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (accept && !req_err) begin
          ram_addr = req_idx;
          if (bus.req_we && req_full) begin
            ram_wren = !reset;
            ram_data = bus.req_wdata;
          end
        end
      end
      S_LOAD: begin
        ram_addr      = idx_q;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = load_data;
      end
      S_RMW: begin
        ram_addr = idx_q;
        ram_wren = !reset;
        ram_data = merge_data;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array memory model, timed response
// and RAM-write scoreboards, directed corner cases, then random traffic.
module tb_dmem_ctrl;
  import mem_pkg::*;

  localparam int            DW    = 32;
  localparam int            DEPTH = 64;
  localparam int            AW    = 32;
  localparam int            IW    = 6;
  localparam logic [AW-1:0] BASE  = '0;
  localparam int            BYTES = DEPTH * 4;

  // ---------------- clock / reset / RAM ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ram_clear = 1'b1;
  logic [IW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  state_e        dbg_state;
  int            cyc = 0;

  dmem_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  dmem_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .ram_addr    (ram_addr),
    .ram_wren    (ram_wren),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_wren) ram_mem[ram_addr] <= ram_data;
      ram_q <= ram_mem[ram_addr];
    end
  end

  // ---------------- model and scoreboard ----------------
  logic [7:0]  ref_mem [BYTES];
  logic [64:0] exp_rsp_q[$];  // {cycle, err, rdata}
  logic [69:0] exp_wr_q[$];   // {cycle, word addr, data}
  int          checks = 0;
  int          fails = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_wr_data;
  int          last_waits;

  function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Decide the outcome of one accepted request from the addressing rules and
  // the byte-level memory image, and schedule what the DUT must show.
  task automatic model(input logic we, input int size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input int acc);
    int          n;
    logic        err;
    logic [63:0] v;
    n   = 1 << size;
    err = (size > 2) || ((addr % n) != 0) || (addr >= 32'(BYTES));
    if (err) begin
      exp_rsp_q.push_back({32'(acc + 1), 1'b1, 32'h0});
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      if (size == 2) begin
        exp_wr_q.push_back({32'(acc), 6'(addr >> 2), ref_word(int'(addr >> 2))});
        exp_rsp_q.push_back({32'(acc + 1), 1'b0, 32'h0});
      end else begin
        exp_wr_q.push_back({32'(acc + 1), 6'(addr >> 2), ref_word(int'(addr >> 2))});
        exp_rsp_q.push_back({32'(acc + 2), 1'b0, 32'h0});
      end
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[addr + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      exp_rsp_q.push_back({32'(acc + 1), 1'b0, v[31:0]});
    end
  endtask

  // Compare process: every negedge outside reset, responses and RAM writes
  // must match the scheduled expectations in content and cycle.
  task automatic monitor();
    logic [64:0] e;
    logic [69:0] w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.rsp_valid) begin
          if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_rsp_q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e[64:33]));
            chk("rsp_err", 64'(bus.rsp_err), 64'(e[32]));
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e[31:0]));
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
          end
        end else if (exp_rsp_q.size() > 0 && int'(exp_rsp_q[0][64:33]) <= cyc) begin
          chk("rsp_missing", 64'd0, 64'd1);
          void'(exp_rsp_q.pop_front());
        end
        if (ram_wren) begin
          if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
          else begin
            w = exp_wr_q.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(w[69:38]));
            chk("wr_addr", 64'(ram_addr), 64'(w[37:32]));
            chk("wr_data", 64'(ram_data), 64'(w[31:0]));
            last_wr_data = ram_data;
          end
        end else if (exp_wr_q.size() > 0 && int'(exp_wr_q[0][69:38]) <= cyc) begin
          chk("wr_missing", 64'd0, 64'd1);
          void'(exp_wr_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic we, input int size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic track, output int acc);
    int waits;
    bus.req_we     = we;
    bus.req_size   = size_e'(size);
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    last_waits = waits;
    if (!bus.req_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      if (track) model(we, size, sgn, addr, wdata, acc);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_rsp_q.size() + exp_wr_q.size()), 64'd0);
      exp_rsp_q.delete();
      exp_wr_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int a0;
    int waits_sum;
    int size;
    logic [31:0] addr;

    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = SZ_B;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_ram_wren", 64'(ram_wren), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_data", 64'(ram_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    ram_clear = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(bus.req_ready), 64'd1);

    // Word store then word load.
    issue(1'b1, 2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, acc);
    issue(1'b0, 2, 1'b0, 32'h10, 32'h0, 1'b1, acc);
    drain();
    chk("lit_load_word", 64'(last_rdata), 64'hDEADBEEF);

    // Byte store via RMW, then signed and unsigned byte loads.
    issue(1'b1, 0, 1'b0, 32'h11, 32'h00000080, 1'b1, acc);
    drain();
    chk("lit_rmw_data", 64'(last_wr_data), 64'hDEAD80EF);
    issue(1'b0, 0, 1'b1, 32'h11, 32'h0, 1'b1, acc);
    drain();
    chk("lit_lb_signed", 64'(last_rdata), 64'hFFFFFF80);
    issue(1'b0, 0, 1'b0, 32'h11, 32'h0, 1'b1, acc);
    drain();
    chk("lit_lb_unsigned", 64'(last_rdata), 64'h00000080);
    issue(1'b0, 1, 1'b1, 32'h12, 32'h0, 1'b1, acc);
    drain();
    chk("lit_lh_signed", 64'(last_rdata), 64'hFFFFDEAD);

    // Misaligned half store, out-of-range and top-word loads.
    issue(1'b1, 1, 1'b0, 32'h13, 32'h0000AAAA, 1'b1, acc);
    drain();
    chk("lit_misalign_err", 64'(last_err), 64'd1);
    issue(1'b0, 2, 1'b0, 32'(BYTES), 32'h0, 1'b1, acc);
    drain();
    chk("lit_oor_err", 64'(last_err), 64'd1);
    chk("lit_oor_rdata", 64'(last_rdata), 64'd0);
    issue(1'b0, 2, 1'b0, 32'(BYTES - 4), 32'h0, 1'b1, acc);
    drain();
    chk("lit_top_word_err", 64'(last_err), 64'd0);
    issue(1'b0, 3, 1'b0, 32'h18, 32'h0, 1'b1, acc);
    drain();
    chk("lit_dword_err", 64'(last_err), 64'd1);

    // Four back-to-back word stores.
    waits_sum = 0;
    issue(1'b1, 2, 1'b0, 32'h40, 32'h01010101, 1'b1, a0);
    for (int i = 1; i < 4; i++) begin
      issue(1'b1, 2, 1'b0, 32'h40 + 32'(4 * i), 32'h01010101 * 32'(i + 1), 1'b1, acc);
      waits_sum += last_waits;
    end
    chk("b2b_span", 64'(acc - a0), 64'd3);
    chk("b2b_waits", 64'(waits_sum), 64'd0);
    drain();

    // Reset asserted during the RMW write cycle.
    issue(1'b1, 2, 1'b0, 32'h20, 32'h11223344, 1'b1, acc);
    drain();
    issue(1'b1, 0, 1'b0, 32'h21, 32'h00000055, 1'b0, acc);
    chk("abort_in_rmw", 64'(dbg_state), 64'(S_RMW));
    reset = 1'b1;
    #1;
    chk("abort_wren", 64'(ram_wren), 64'd0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 64'(bus.req_ready), 64'd1);
    issue(1'b0, 2, 1'b0, 32'h20, 32'h0, 1'b1, acc);
    drain();
    chk("lit_abort_unchanged", 64'(last_rdata), 64'h11223344);

    // Random traffic, biased to aligned in-range addresses.
    for (int k = 0; k < 250; k++) begin
      size = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(BYTES - 8, BYTES + 16))
                                         : 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      issue(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
            $urandom, 1'b1, acc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();

    for (int w = 0; w < DEPTH; w++) chk("ram_word", 64'(ram_mem[w]), 64'(ref_word(w)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
